riscv_data_mem_arbiter: RTL

- Shares one data-memory port (req/gnt/rvalid protocol) between two masters: master 0 is the load/store unit, master 1 is the debug/DMA port.
- Arbitrates with round-robin priority and locks its choice until the slave grants.
- Records the owner of each granted transaction in an in-order FIFO and routes rvalid/rdata back to that owner.
- Sits between the core's LSU/debug unit and the data memory or bus.

---
 rtl/riscv_data_mem_arbiter.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/riscv_data_mem_arbiter.sv
// Two-master round-robin arbiter for the core's data-memory port.
// Grant order is kept in an owner FIFO so responses reach the right master.
module riscv_data_mem_arbiter #(
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter int unsigned CNT_W           = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             m0_req_i,
  input  logic [31:0]      m0_addr_i,
  input  logic             m0_we_i,
  input  logic [3:0]       m0_be_i,
  input  logic [31:0]      m0_wdata_i,
  output logic             m0_gnt_o,
  output logic             m0_err_o,
  output logic             m0_rvalid_o,
  output logic [31:0]      m0_rdata_o,
  input  logic             m1_req_i,
  input  logic [31:0]      m1_addr_i,
  input  logic             m1_we_i,
  input  logic [3:0]       m1_be_i,
  input  logic [31:0]      m1_wdata_i,
  output logic             m1_gnt_o,
  output logic             m1_err_o,
  output logic             m1_rvalid_o,
  output logic [31:0]      m1_rdata_o,
  output logic             data_req_o,
  output logic [31:0]      data_addr_o,
  output logic             data_we_o,
  output logic [3:0]       data_be_o,
  output logic [31:0]      data_wdata_o,
  input  logic             data_gnt_i,
  input  logic             data_err_i,
  input  logic             data_rvalid_i,
  input  logic [31:0]      data_rdata_i,
  output logic [CNT_W-1:0] outstanding_o,
  output logic             busy_o,
  output logic             spurious_rvalid_o
);

  localparam int unsigned PW =
    (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam logic [PW-1:0] LAST = PW'(MAX_OUTSTANDING - 1);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(MAX_OUTSTANDING);

  typedef enum logic {
    ARB_IDLE,
    ARB_HOLD
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic                       r_lock_id;
  logic                       w_lock_nxt;
  logic                       r_last_grant;
  logic [CNT_W-1:0]           r_cnt;
  logic [MAX_OUTSTANDING-1:0] r_owner;
  logic [PW-1:0]              r_wptr;
  logic [PW-1:0]              r_rptr;

  logic w_pop;
  logic w_full;
  logic w_win;
  logic w_sel;
  logic w_req;
  logic w_push;
  logic w_head;

  assign w_pop  = data_rvalid_i && (r_cnt != '0);
  assign w_full = (r_cnt == FULL);
  assign w_head = r_owner[r_rptr];

  // Tie goes to whichever master did not win last time.
  assign w_win = (m0_req_i && m1_req_i) ? ~r_last_grant : m1_req_i;

  always_comb begin
    w_state_nxt = r_state;
    w_lock_nxt  = r_lock_id;
    w_sel       = 1'b0;
    w_req       = 1'b0;
    w_push      = 1'b0;
    unique case (r_state)
      ARB_IDLE: begin
        if ((!w_full || w_pop) && (m0_req_i || m1_req_i)) begin
          w_sel = w_win;
          w_req = 1'b1;
          if (data_gnt_i) begin
            w_push = 1'b1;
          end else begin
            w_state_nxt = ARB_HOLD;
            w_lock_nxt  = w_win;
          end
        end
      end
      ARB_HOLD: begin
        w_sel = r_lock_id;
        w_req = r_lock_id ? m1_req_i : m0_req_i;
        if (!w_req) begin
          w_state_nxt = ARB_IDLE;
        end else if (data_gnt_i) begin
          w_push      = 1'b1;
          w_state_nxt = ARB_IDLE;
        end
      end
      default: w_state_nxt = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ARB_IDLE;
      r_lock_id    <= 1'b0;
      r_last_grant <= 1'b1;
      r_cnt        <= '0;
      r_owner      <= '0;
      r_wptr       <= '0;
      r_rptr       <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_lock_id <= w_lock_nxt;
      if (w_push) begin
        r_owner[r_wptr] <= w_sel;
        r_wptr          <= (r_wptr == LAST) ? '0 : r_wptr + 1'b1;
        r_last_grant    <= w_sel;
      end
      if (w_pop) begin
        r_rptr <= (r_rptr == LAST) ? '0 : r_rptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  assign data_req_o   = w_req;
  assign data_addr_o  = !w_req ? '0 : (w_sel ? m1_addr_i  : m0_addr_i);
  assign data_we_o    = w_req && (w_sel ? m1_we_i : m0_we_i);
  assign data_be_o    = !w_req ? '0 : (w_sel ? m1_be_i    : m0_be_i);
  assign data_wdata_o = !w_req ? '0 : (w_sel ? m1_wdata_i : m0_wdata_i);

  assign m0_gnt_o = w_push && !w_sel;
  assign m1_gnt_o = w_push &&  w_sel;
  assign m0_err_o = m0_gnt_o && data_err_i;
  assign m1_err_o = m1_gnt_o && data_err_i;

  assign m0_rvalid_o = w_pop && !w_head;
  assign m1_rvalid_o = w_pop &&  w_head;
  assign m0_rdata_o  = data_rdata_i;
  assign m1_rdata_o  = data_rdata_i;

  assign outstanding_o     = r_cnt;
  assign busy_o            = (r_cnt != '0) || w_req;
  assign spurious_rvalid_o = data_rvalid_i && (r_cnt == '0);

endmodule
